// File: rtl/uart_cfg_regfile.sv
// Byte-stream configuration register file.
// A header byte selects a register and a direction. A write frame carries
// DATA_BYTES little-endian data bytes, which are committed atomically after
// the last byte. A read frame streams the register back over m_axis.
// A stalled write frame is abandoned after TIMEOUT_CYC idle cycles.
module uart_cfg_regfile #(
  parameter int                          NUM_REGS    = 4,
  parameter int                          REG_W       = 16,
  parameter logic [NUM_REGS*REG_W-1:0]   RST_VAL     = '0,
  parameter int                          TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [NUM_REGS*REG_W-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]       cfg_wr,
  output logic                      err,
  output logic                      busy
);

  localparam int DATA_BYTES = (REG_W + 7) / 8;
  localparam int SW         = DATA_BYTES * 8;
  localparam int BCW        = $clog2(DATA_BYTES + 1);
  localparam int TW         = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [6:0]     NREGS7   = 7'(NUM_REGS);
  localparam logic [BCW-1:0] LAST_B   = BCW'(DATA_BYTES - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WDATA, RSEND} state_e;

  state_e                         state_q, state_d;
  logic [5:0]                     addr_q, addr_d;
  logic [BCW-1:0]                 bcnt_q, bcnt_d;
  logic [TW-1:0]                  tocnt_q, tocnt_d;
  logic [SW-1:0]                  shadow_q, shadow_d;
  logic [SW-1:0]                  rbuf_q, rbuf_d;
  logic                           tvalid_q, tvalid_d;
  logic [NUM_REGS-1:0][REG_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            wr_q, wr_d;
  logic                           err_q, err_d;

  logic          s_hs, m_hs, last_b, addr_hit, hdr_hit;
  logic [SW-1:0] rd_val;

  assign s_axis_tready = (state_q != RSEND);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = tvalid_q && m_axis_tready;
  assign last_b        = (bcnt_q == LAST_B);
  assign addr_hit      = ({1'b0, addr_q} < NREGS7);
  assign hdr_hit       = ({1'b0, s_axis_tdata[5:0]} < NREGS7);

  assign m_axis_tdata  = rbuf_q[7:0];
  assign m_axis_tvalid = tvalid_q;
  assign cfg_regs      = regs_q;
  assign cfg_wr        = wr_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE);

  // Read-back value for the address carried in the incoming header byte.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (s_axis_tdata[5:0] == 6'(i)) rd_val[REG_W-1:0] = regs_q[i];
    end
  end

  // Frame parser: header decode, data capture, commit, read-back, timeout.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bcnt_d   = bcnt_q;
    tocnt_d  = tocnt_q;
    shadow_d = shadow_q;
    rbuf_d   = rbuf_q;
    tvalid_d = tvalid_q;
    regs_d   = regs_q;
    wr_d     = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_hs) begin
          if (s_axis_tdata[6]) begin
            err_d = 1'b1;
          end else begin
            addr_d = s_axis_tdata[5:0];
            bcnt_d = '0;
            if (s_axis_tdata[7]) begin
              state_d  = WDATA;
              tocnt_d  = '0;
              shadow_d = '0;
            end else begin
              state_d  = RSEND;
              tvalid_d = 1'b1;
              rbuf_d   = rd_val;
              err_d    = !hdr_hit;
            end
          end
        end
      end
      WDATA: begin
        if (s_hs) begin
          tocnt_d = '0;
          for (int j = 0; j < DATA_BYTES; j++) begin
            if (bcnt_q == BCW'(j)) shadow_d[j*8 +: 8] = s_axis_tdata;
          end
          if (last_b) begin
            state_d = IDLE;
            if (addr_hit) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 6'(i)) begin
                  regs_d[i] = shadow_d[REG_W-1:0];
                  wr_d[i]   = 1'b1;
                end
              end
            end else begin
              err_d = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (TIMEOUT_CYC > 0) begin
          if (tocnt_q == TO_LAST) begin
            err_d    = 1'b1;
            state_d  = IDLE;
            tocnt_d  = '0;
            shadow_d = '0;
          end else begin
            tocnt_d = tocnt_q + 1'b1;
          end
        end
      end
      RSEND: begin
        if (m_hs) begin
          rbuf_d = rbuf_q >> 8;
          if (last_b) begin
            tvalid_d = 1'b0;
            state_d  = IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame without committing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      bcnt_q   <= '0;
      tocnt_q  <= '0;
      shadow_q <= '0;
      rbuf_q   <= '0;
      tvalid_q <= 1'b0;
      regs_q   <= RST_VAL;
      wr_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bcnt_q   <= bcnt_d;
      tocnt_q  <= tocnt_d;
      shadow_q <= shadow_d;
      rbuf_q   <= rbuf_d;
      tvalid_q <= tvalid_d;
      regs_q   <= regs_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_cfg_regfile.sv
// Directed bench for uart_cfg_regfile (4 x 16-bit regs, 16-cycle timeout).
module tb_uart_cfg_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] cfg_regs;
  logic [3:0]  cfg_wr;
  logic        err;
  logic        busy;

  int vecs = 0;
  int miss = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int bad_cnt = 0;
  int e0;

  uart_cfg_regfile #(
    .NUM_REGS(4), .REG_W(16), .RST_VAL(64'h0), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .cfg_regs(cfg_regs), .cfg_wr(cfg_wr), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping and the err/cfg_wr exclusivity invariants.
  always @(posedge clk) begin
    if (err) err_cnt <= err_cnt + 1;
    if (|cfg_wr) wr_cnt <= wr_cnt + 1;
    if ((err && |cfg_wr) || !$onehot0(cfg_wr)) bad_cnt <= bad_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a byte and return one cycle after it is accepted.
  task automatic send(input logic [7:0] b);
    int n = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin step(); n++; end
    if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
    step();
    s_tvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b0;
    step();
    chk("rst_regs", cfg_regs, 64'h0);
    chk("rst_wr", 64'(cfg_wr), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_tdata", 64'(m_tdata), 64'h0);
    chk("rst_tready", 64'(s_tready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    step();
    rst = 1'b0;
    step();

    // Write 0xBEEF to reg2.
    send(8'h82);
    chk("w_busy", 64'(busy), 64'h1);
    send(8'hEF);
    chk("w_partial", cfg_regs, 64'h0);
    chk("w_partial_wr", 64'(cfg_wr), 64'h0);
    send(8'hBE);
    chk("w_commit", cfg_regs, 64'h0000_BEEF_0000_0000);
    chk("w_strobe", 64'(cfg_wr), 64'h4);
    step();
    chk("w_strobe_off", 64'(cfg_wr), 64'h0);
    chk("w_idle", 64'(busy), 64'h0);

    // Read reg2 with 5 cycles of backpressure.
    send(8'h02);
    chk("r_tvalid", 64'(m_tvalid), 64'h1);
    chk("r_b0", 64'(m_tdata), 64'hEF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r_hold", {55'h0, s_tready, m_tvalid, m_tdata}, {55'h0, 1'b0, 1'b1, 8'hEF});
    end
    m_tready = 1'b1;
    step();
    chk("r_b1", {55'h0, busy, m_tvalid, m_tdata}, {55'h0, 1'b1, 1'b1, 8'hBE});
    step();
    chk("r_done", {62'h0, busy, m_tvalid}, 64'h0);

    // Unmapped write then unmapped read.
    e0 = err_cnt;
    send(8'h85);
    send(8'h11);
    send(8'h22);
    chk("uw_err", {62'h0, err, busy}, 64'h2);
    chk("uw_wr", 64'(cfg_wr), 64'h0);
    chk("uw_regs", cfg_regs, 64'h0000_BEEF_0000_0000);
    step(); step();
    chk("uw_one_err", 64'(err_cnt - e0), 64'h1);
    send(8'h05);
    chk("ur_b0", {54'h0, err, m_tvalid, m_tdata}, {54'h0, 1'b1, 1'b1, 8'h00});
    step();
    chk("ur_b1", {54'h0, err, m_tvalid, m_tdata}, {54'h0, 1'b0, 1'b1, 8'h00});
    step();
    chk("ur_done", {62'h0, busy, m_tvalid}, 64'h0);
    m_tready = 1'b0;

    // Reserved bit header is rejected, then a normal write.
    send(8'hC1);
    chk("rsv", {61'h0, err, busy, s_tready}, 64'h5);
    send(8'h81);
    send(8'h34);
    send(8'h12);
    chk("rsv_w", cfg_regs, 64'h0000_BEEF_1234_0000);
    chk("rsv_wr", 64'(cfg_wr), 64'h2);

    // Timeout after 16 idle cycles inside a write frame.
    send(8'h81);
    send(8'h34);
    for (int i = 0; i < 15; i++) step();
    chk("to_early", {62'h0, err, busy}, 64'h1);
    step();
    chk("to_fire", {62'h0, err, busy}, 64'h2);
    chk("to_regs", cfg_regs, 64'h0000_BEEF_1234_0000);
    send(8'h81);
    send(8'h78);
    send(8'h56);
    chk("to_w", cfg_regs, 64'h0000_BEEF_5678_0000);
    chk("to_wr", 64'(cfg_wr), 64'h2);

    // Reset in the middle of a write frame.
    send(8'h80);
    send(8'hAA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_regs", cfg_regs, 64'h0);
    chk("mr_state", {61'h0, busy, s_tready, |cfg_wr}, 64'h2);
    m_tready = 1'b1;
    send(8'h00);
    chk("mr_b0", {54'h0, busy, m_tvalid, m_tdata}, {54'h0, 1'b1, 1'b1, 8'h00});
    step();
    chk("mr_b1", {54'h0, busy, m_tvalid, m_tdata}, {54'h0, 1'b1, 1'b1, 8'h00});
    step();
    chk("mr_done", {61'h0, busy, m_tvalid, |cfg_wr}, 64'h0);
    step();

    chk("tot_err", 64'(err_cnt), 64'd4);
    chk("tot_wr", 64'(wr_cnt), 64'd3);
    chk("invariant", 64'(bad_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/uart_cfg_regfile.md
Name: uart_cfg_regfile

Overview:
- Byte-stream configuration register file sitting between the UART receiver/transmitter and the core's configuration inputs.
- Generalises the fixed gate/loop/aer 2-bit address decode to framed multi-byte writes into NUM_REGS registers of REG_W bits.
- Adds read-back over the transmit stream, atomic per-register commit, and a frame timeout.

Parameters:
- NUM_REGS, 4, number of config registers (1..64)
- REG_W, 16, register width in bits (1..64); DATA_BYTES = ceil(REG_W/8)
- RST_VAL, 0, NUM_REGS*REG_W flat reset value; register i occupies bits [i*REG_W +: REG_W]
- TIMEOUT_CYC, 1024, idle cycles allowed between bytes inside a frame; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- s_axis_tdata  in  8  received byte from the UART receiver
- s_axis_tvalid  in  1  received byte valid
- s_axis_tready  out  1  byte accepted when tvalid and tready are both high
- m_axis_tdata  out  8  read-back byte to the UART transmitter
- m_axis_tvalid  out  1  read-back byte valid
- m_axis_tready  in  1  transmitter ready
- cfg_regs  out  NUM_REGS*REG_W  current register contents, flat
- cfg_wr  out  NUM_REGS  one-cycle commit strobe per register
- err  out  1  one-cycle error pulse
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: cfg_regs=RST_VAL, cfg_wr=0, err=0, m_axis_tvalid=0, m_axis_tdata=0, state=IDLE, s_axis_tready=1, busy=0. rst has priority over every other event and aborts any frame in progress without committing.
- Header byte fields: bit7=W (1 write, 0 read), bit6 reserved (must be 0), bits[5:0]=address.
- IDLE: s_axis_tready=1. On header accept:
  - bit6=1: err pulses the next cycle; byte dropped; remain IDLE.
  - W=1: latch address, clear byte counter, enter WDATA.
  - W=0: latch address, load the read buffer (the register value, or 0 if address >= NUM_REGS), enter RSEND.
- WDATA: s_axis_tready=1. Accepted bytes are stored little-endian into a shadow register (byte 0 = bits[7:0]); bits above REG_W in the top byte are ignored.
  - On the DATA_BYTES-th byte: if address < NUM_REGS, the shadow is copied into the register. The new value and cfg_wr[addr]=1 both appear on the cycle after that handshake.
  - If address >= NUM_REGS: all bytes are consumed, nothing is written, and err pulses at the same point.
  - Either way, return to IDLE.
  - cfg_regs never shows a partial write.
- RSEND: s_axis_tready=0.
  - m_axis_tvalid rises the cycle after the header accept, with byte 0.
  - tdata is held stable while tvalid=1 and tready=0.
  - On each handshake, advance to the next byte on the following cycle. Back-to-back handshakes give 1 byte/cycle.
  - After the DATA_BYTES-th handshake: tvalid=0, return to IDLE.
  - Unmapped address: send DATA_BYTES bytes of 0x00, and err pulses when the header is accepted (the cycle after).
- Timeout (TIMEOUT_CYC>0, WDATA only):
  - The counter clears on every accepted byte and on entering WDATA, and increments every other WDATA cycle.
  - On reaching TIMEOUT_CYC: err pulses, the shadow is discarded, return to IDLE. The next byte is treated as a header.
  - RSEND never times out; m_axis_tready may stall indefinitely.
- Counters: byte counter width clog2(DATA_BYTES+1); timeout counter width clog2(TIMEOUT_CYC+1). Neither wraps; both saturate or clear as described.
- At most one cfg_wr bit is high in any cycle. err and cfg_wr are never high in the same cycle.

Test Plan:
- Write, defaults: bytes 0x82,0xEF,0xBE -> cfg_regs[47:32]=0xBEEF and cfg_wr=4'b0100 one cycle after the 0xBE accept; cfg_regs unchanged after 0xEF; other regs remain RST_VAL.
- Read with backpressure: after the above, byte 0x02, m_axis_tready low for 5 cycles then high -> tdata 0xEF held stable, then 0xEF, 0xBE; s_axis_tready=0 throughout; busy falls after the second handshake.
- Unmapped: 0x85,0x11,0x22 -> exactly one err pulse, cfg_regs unchanged, cfg_wr never set. Then 0x05 -> emits 0x00,0x00 with one err pulse.
- Reserved bit: 0xC1 -> err pulse, state stays IDLE, s_axis_tready stays 1. Next 0x81,0x34,0x12 -> reg1=0x1234.
- Timeout (TIMEOUT_CYC=16): 0x81,0x34, then 16 idle cycles -> err pulse, reg1 unchanged. Then 0x81,0x78,0x56 -> reg1=0x5678, cfg_wr=4'b0010.
- Reset mid-frame: 0x80,0xAA, assert rst 1 cycle, then 0x00 -> cfg_regs=RST_VAL after rst, no commit of 0xAA; the 0x00 is parsed as a read of reg0 and returns 0x00,0x00.
